// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array stream path.
// The feed packer and the stream wrapper both import this package so that
// operand geometry and the SOB/EOB flag positions stay in agreement.
package sa_pkg;

    localparam int PKG_DATA_WIDTH = 1024;
    localparam int ARITH_IN_WIDTH = 32;
    localparam int N              = 16;
    localparam int M              = 15;
    localparam int SOB_BIT        = PKG_DATA_WIDTH - 2;
    localparam int EOB_BIT        = PKG_DATA_WIDTH - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sa_feed_skid.sv
// Two-entry rts/rtr skid buffer of generic width.
// Upstream ready comes only from the registered fill level, so it never
// depends combinationally on the downstream ready. With out_ready held high
// the buffer sits at one entry and passes one beat per cycle.
// out_data is forced to zero whenever out_valid is low.
module sa_feed_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? head : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Fill level: push and pop in the same cycle leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage: head is always the oldest beat, tail the second one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (pop) begin
            if (count == 2'd2) begin
                head <= tail;
            end else if (push) begin
                head <= in_data;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                head <= in_data;
            end else begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/sa_feed_packer.sv
// Feed packer: joins one row of A and one column of B into a single beat per
// k-step, tags the first/last beat of each K-beat block with SOB/EOB and
// hands beats downstream through a two-entry skid buffer.
// Optional build macro SA_FEED_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles where a beat waits on downstream (cleared per block).
module sa_feed_packer #(
    parameter int DATA_WIDTH     = 1024,
    parameter int ARITH_IN_WIDTH = sa_pkg::ARITH_IN_WIDTH,
    parameter int N              = sa_pkg::N,
    parameter int M              = sa_pkg::M,
    parameter int K_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [K_WIDTH-1:0]          cfg_k_i,
    input  logic                        a_rts_i,
    output logic                        a_rtr_o,
    input  logic [N*ARITH_IN_WIDTH-1:0] a_data_i,
    input  logic                        b_rts_i,
    output logic                        b_rtr_o,
    input  logic [M*ARITH_IN_WIDTH-1:0] b_data_i,
    output logic                        rts_o,
    input  logic                        rtr_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        done_o,
    output logic                        cfg_err_o
`ifdef SA_FEED_STALL_CNT_EN
    ,output logic [31:0]                stall_cnt_o
`endif
);

    import sa_pkg::state_t;
    import sa_pkg::IDLE;
    import sa_pkg::RUN;

    localparam int A_W     = N * ARITH_IN_WIDTH;
    localparam int B_W     = M * ARITH_IN_WIDTH;
    localparam int SOB_POS = DATA_WIDTH - 2;
    localparam int EOB_POS = DATA_WIDTH - 1;

    if ((N + M) * ARITH_IN_WIDTH > DATA_WIDTH - 2) begin : g_width_check
        $error("sa_feed_packer: A and B words do not fit below the flag bits");
    end

    state_t              state;
    state_t              state_next;
    logic [K_WIDTH-1:0]  k_reg;
    logic [K_WIDTH-1:0]  cnt;
    logic                is_sob;
    logic                is_eob;
    logic                fire;
    logic                cfg_accept;
    logic                skid_ready;
    logic [DATA_WIDTH-1:0] beat;

    assign is_sob = (cnt == '0);
    assign is_eob = (cnt == k_reg - {{(K_WIDTH-1){1'b0}}, 1'b1});

    // Next-state and handshake outputs: A and B are only ever taken together.
    always_comb begin
        state_next  = state;
        cfg_ready_o = 1'b0;
        cfg_accept  = 1'b0;
        a_rtr_o     = 1'b0;
        b_rtr_o     = 1'b0;
        fire        = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i && (cfg_k_i != '0)) begin
                    cfg_accept = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_rtr_o = b_rts_i & skid_ready;
                b_rtr_o = a_rts_i & skid_ready;
                fire    = a_rts_i & b_rts_i & skid_ready;
                if (fire && is_eob) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Block length latch and beat position; position holds at K-1 on EOB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg <= '0;
            cnt   <= '0;
        end else if (cfg_accept) begin
            k_reg <= cfg_k_i;
            cnt   <= '0;
        end else if (fire && !is_eob) begin
            cnt <= cnt + {{(K_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Sticky error for a zero-length block request, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_o <= 1'b0;
        end else if ((state == IDLE) && cfg_valid_i && (cfg_k_i == '0)) begin
            cfg_err_o <= 1'b1;
        end
    end

    // Beat assembly: A low, B above it, flags on top, everything else zero.
    always_comb begin
        beat                  = '0;
        beat[A_W-1:0]         = a_data_i;
        beat[A_W+B_W-1:A_W]   = b_data_i;
        beat[SOB_POS]         = is_sob;
        beat[EOB_POS]         = is_eob;
    end

    sa_feed_skid #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fire),
        .in_ready  (skid_ready),
        .in_data   (beat),
        .out_valid (rts_o),
        .out_ready (rtr_i),
        .out_data  (data_o)
    );

    assign done_o = rts_o & rtr_i & data_o[EOB_POS];

`ifdef SA_FEED_STALL_CNT_EN
    // Saturating count of cycles where a beat is offered but not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 32'd0;
        end else if (cfg_accept) begin
            stall_cnt_o <= 32'd0;
        end else if (rts_o && !rtr_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_feed_packer.sv
// Bench for sa_feed_packer: directed block table, hand sequences for zero-K
// and mid-block reset, and randomized traffic checked by a scoreboard that
// predicts beats from the block rules (pairing order, SOB/EOB by position).
module tb_sa_feed_packer;

    localparam int DW = 1024;
    localparam int W  = 32;
    localparam int NA = 16;
    localparam int MB = 15;
    localparam int KW = 16;
    localparam int AW = NA * W;
    localparam int BW = MB * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic          a_rts = 1'b0;
    logic [AW-1:0] a_data = '0;
    logic          b_rts = 1'b0;
    logic [BW-1:0] b_data = '0;
    logic          rtr = 1'b1;

    logic          cfg_ready;
    logic          a_rtr;
    logic          b_rtr;
    logic          rts;
    logic [DW-1:0] data;
    logic          done;
    logic          cfg_err;
`ifdef SA_FEED_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    sa_feed_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_k_i     (cfg_k),
        .a_rts_i     (a_rts),
        .a_rtr_o     (a_rtr),
        .a_data_i    (a_data),
        .b_rts_i     (b_rts),
        .b_rtr_o     (b_rtr),
        .b_data_i    (b_data),
        .rts_o       (rts),
        .rtr_i       (rtr),
        .data_o      (data),
        .done_o      (done),
        .cfg_err_o   (cfg_err)
`ifdef SA_FEED_STALL_CNT_EN
        ,.stall_cnt_o (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_idle = 1'b1;
    int            m_k = 0;
    int            m_pos = 0;
    bit            m_err = 1'b0;
    logic [31:0]   m_stall = 32'd0;
    logic [DW-1:0] exp_q[$];
    int            acc_cnt = 0;
    int            beats_seen = 0;
    int            dones_seen = 0;
    int            cyc = 0;
    int            sob_cyc = 0;
    int            eob_cyc = 0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] e_beat;
    bit            a_take;
    bit            b_take;

    typedef struct {
        int k;
        int b_odd;
        int stall_at;
        int stall_len;
        int exp_beats;
        int exp_span;
        int exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkBeat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = 0;
            for (int i = DW/W - 1; i >= 0; i--) begin
                if (act[i*W +: W] !== exp[i*W +: W]) first = i;
            end
            $display("[TB] FAIL %s: word %0d got %h expected %h (t=%0t)",
                     name, first, act[first*W +: W], exp[first*W +: W], $time);
        end
    endtask

    function automatic logic [AW-1:0] randA();
        logic [AW-1:0] r;
        for (int i = 0; i < NA; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    function automatic logic [BW-1:0] randB();
        logic [BW-1:0] r;
        for (int i = 0; i < MB; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] mkBeat(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                             input bit sob, input bit eob);
        logic [DW-1:0] r;
        r = '0;
        r[AW-1:0]     = a;
        r[AW+BW-1:AW] = b;
        r[DW-2]       = sob;
        r[DW-1]       = eob;
        return r;
    endfunction

    task automatic applyStimulus(input bit cv, input int k, input bit av, input bit bv, input bit r);
        @(posedge clk);
        #1;
        cfg_valid = cv;
        cfg_k     = k[KW-1:0];
        a_rts     = av;
        b_rts     = bv;
        rtr       = r;
        a_data    = randA();
        b_data    = randB();
    endtask

    // Scoreboard: sample mid-cycle, predict what the coming edge transfers.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            checkOutput("rst_rts", rts, 0);
            checkOutput("rst_cfg_ready", cfg_ready, 1);
            checkOutput("rst_a_rtr", a_rtr, 0);
            checkOutput("rst_b_rtr", b_rtr, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_cfg_err", cfg_err, 0);
            checkOutput("rst_data_zero", {63'd0, |data}, 0);
            m_idle = 1'b1;
            m_pos = 0;
            m_k = 0;
            m_err = 1'b0;
            m_stall = 32'd0;
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            checkOutput("cfg_ready", cfg_ready, m_idle);
            checkOutput("cfg_err", cfg_err, m_err);
            if (!rts) checkOutput("data_zero_when_idle", {63'd0, |data}, 0);
            if (prev_hold) begin
                checkOutput("hold_rts", rts, 1);
                checkBeat("hold_data", data, prev_data);
            end
`ifdef SA_FEED_STALL_CNT_EN
            checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
            if (rts && rtr) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat_count", 1, 0);
                end else begin
                    e_beat = exp_q.pop_front();
                    checkBeat("beat", data, e_beat);
                    checkOutput("done", done, e_beat[DW-1]);
                    if (e_beat[DW-2]) sob_cyc = cyc;
                    if (e_beat[DW-1]) eob_cyc = cyc;
                end
                beats_seen++;
            end else begin
                checkOutput("done_no_xfer", done, 0);
            end
            if (done) dones_seen++;

            a_take = a_rts & a_rtr;
            b_take = b_rts & b_rtr;
            checkOutput("ab_pair", a_take, b_take);

            if (rts && !rtr && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (m_idle) begin
                checkOutput("idle_take", a_take, 0);
                if (cfg_valid) begin
                    if (cfg_k != 0) begin
                        m_idle = 1'b0;
                        m_k = int'(cfg_k);
                        m_pos = 0;
                        m_stall = 32'd0;
                        acc_cnt++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (a_take && b_take) begin
                exp_q.push_back(mkBeat(a_data, b_data, m_pos == 0, m_pos == m_k - 1));
                m_pos++;
                if (m_pos == m_k) m_idle = 1'b1;
            end
            prev_hold = rts & ~rtr;
            prev_data = data;
        end
    end

    task automatic requestBlock(input int k);
        int acc0;
        acc0 = acc_cnt;
        applyStimulus(1, k, 0, 0, 1);
        for (int t = 0; t < 10 && acc_cnt == acc0; t++) applyStimulus(1, k, 0, 0, 1);
    endtask

    task automatic runVector(input vec_t v);
        int d0;
        int b0;
        bit bv;
        bit r;
        requestBlock(v.k);
        d0 = dones_seen;
        b0 = beats_seen;
        for (int c = 0; c < 200 && dones_seen == d0; c++) begin
            bv = (v.b_odd != 0) ? (c % 2 == 1) : 1'b1;
            r  = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
            applyStimulus(0, 0, 1, bv, r);
        end
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("blk_done_count", dones_seen - d0, 1);
        checkOutput("blk_beats", beats_seen - b0, v.exp_beats);
        if (v.exp_span >= 0) checkOutput("blk_span", eob_cyc - sob_cyc, v.exp_span);
`ifdef SA_FEED_STALL_CNT_EN
        checkOutput("blk_stall_cnt", stall_cnt, v.exp_stall);
`endif
    endtask

    initial begin
        int d0;
        int b0;
        int k;
        vecs[0] = '{k: 4, b_odd: 0, stall_at: -1, stall_len: 0, exp_beats: 4, exp_span: 3, exp_stall: 0};
        vecs[1] = '{k: 1, b_odd: 0, stall_at: -1, stall_len: 0, exp_beats: 1, exp_span: 0, exp_stall: 0};
        vecs[2] = '{k: 8, b_odd: 0, stall_at: 3,  stall_len: 5, exp_beats: 8, exp_span: -1, exp_stall: 5};
        vecs[3] = '{k: 3, b_odd: 1, stall_at: -1, stall_len: 0, exp_beats: 3, exp_span: 4, exp_stall: 0};
        vecs[4] = '{k: 2, b_odd: 0, stall_at: -1, stall_len: 0, exp_beats: 2, exp_span: 1, exp_stall: 0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) runVector(vecs[i]);

        // Zero-length request: sticky error, no block starts
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        #3;
        checkOutput("k0_err", cfg_err, 1);
        checkOutput("k0_idle", cfg_ready, 1);
        checkOutput("k0_no_beat", rts, 0);
        runVector(vecs[4]);

        // Reset while beat 2 of a K=6 block is in flight
        requestBlock(6);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_rts", rts, 0);
        checkOutput("mid_rst_cfg_ready", cfg_ready, 1);
        checkOutput("mid_rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runVector(vecs[4]);

        // Randomized traffic
        for (int blk = 0; blk < 20; blk++) begin
            k = $urandom_range(1, 6);
            requestBlock(k);
            d0 = dones_seen;
            b0 = beats_seen;
            for (int c = 0; c < 300 && dones_seen == d0; c++) begin
                applyStimulus(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 9) < 7);
            end
            for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 0, 1);
            checkOutput("rand_done_count", dones_seen - d0, 1);
            checkOutput("rand_beats", beats_seen - b0, k);
        end

        repeat (3) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("leftover_beats", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_feed_packer.md
Name: sa_feed_packer

Overview:
- Upstream stage of the systolic-array stream wrapper.
- Joins a row-of-A stream (N words) and a column-of-B stream (M words) into one DATA_WIDTH beat per k-step.
- Tags the first beat of each block with SOB and the last with EOB, and delivers beats over the team's rts/rtr handshake.
- Block length K is programmed per block through a config handshake.

Parameters:
- DATA_WIDTH, 1024, output bus width.
- ARITH_IN_WIDTH, 32, width of one arithmetic input word.
- N, 16, number of A words per beat.
- M, 15, number of B words per beat.
- K_WIDTH, 16, width of the block-length field.
- Elaboration check: (N+M)*ARITH_IN_WIDTH <= DATA_WIDTH-2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid_i  in  1  block-length request.
- cfg_ready_o  out  1  high only in IDLE.
- cfg_k_i  in  K_WIDTH  beats in the next block.
- a_rts_i  in  1  A word valid.
- a_rtr_o  out  1  A ready.
- a_data_i  in  N*ARITH_IN_WIDTH  one row of A.
- b_rts_i  in  1  B word valid.
- b_rtr_o  out  1  B ready.
- b_data_i  in  M*ARITH_IN_WIDTH  one column of B.
- rts_o  out  1  output beat valid.
- rtr_i  in  1  downstream ready.
- data_o  out  DATA_WIDTH  packed beat.
- done_o  out  1  one-cycle pulse when the EOB beat is accepted downstream.
- cfg_err_o  out  1  sticky; set when K=0 is requested.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, beat counter=0, skid buffer empty. All outputs 0 except cfg_ready_o=1.
- Beat layout:
  - bits [N*W-1:0] = a_data_i.
  - bits [(N+M)*W-1:N*W] = b_data_i.
  - bit DATA_WIDTH-2 = SOB, bit DATA_WIDTH-1 = EOB.
  - All other bits 0.
- FSM states:
  - IDLE: cfg_ready_o=1, a_rtr_o=b_rtr_o=0.
    - cfg_valid_i & cfg_k_i!=0: latch K, cnt=0, go to RUN.
    - cfg_valid_i & cfg_k_i==0: set cfg_err_o, stay IDLE.
  - RUN: join fires when a_rts_i & b_rts_i & skid-not-full.
    - a_rtr_o = b_rtr_o = b_rts_i & skid-not-full (resp. a_rts_i & skid-not-full), so A and B are always consumed in the same cycle and never singly.
    - On fire: push beat with SOB=(cnt==0), EOB=(cnt==K-1), then cnt++.
    - On fire with EOB: go to IDLE. Accepting the next config does not wait for the skid to drain.
    - K=1 gives a single beat with SOB=EOB=1.
- Output stage: 2-entry skid buffer.
  - Latency 1 cycle from fire to rts_o.
  - Sustains 1 beat/cycle when rtr_i stays high.
  - a_rtr_o/b_rtr_o never depend combinationally on rtr_i.
  - data_o is held stable while rts_o & ~rtr_i.
  - data_o=0 whenever rts_o=0.
- done_o: asserted the cycle the EOB beat transfers (rts_o & rtr_i).
- Counter wraps never occur: cnt stops at K-1 by construction.
- Mid-block reset: all in-flight beats are dropped, FSM returns to IDLE, no done_o.
- cfg_valid_i during RUN is ignored (cfg_ready_o=0).
- cfg_err_o clears only on reset.

Optional Feature:
- Macro SA_FEED_STALL_CNT_EN.
- When defined: adds output stall_cnt_o (32 bits), which counts cycles with rts_o & ~rtr_i.
  - Saturates at 0xFFFFFFFF.
  - Resets to 0 on rst_n and on each cfg accept.
- When undefined: no port and no logic.

Decomposition:
- Shared package sa_pkg:
  - constants ARITH_IN_WIDTH, N, M, SOB_BIT, EOB_BIT.
  - fsm enum state_t {IDLE, RUN}.
  - These are shared with the stream wrapper so the flag positions match.
- One sub-module sa_feed_skid: generic-width 2-entry rts/rtr skid buffer with async active-low reset.

Test Plan:
- K=4, A/B always valid, rtr_i=1 -> 4 beats on consecutive cycles. SOB only on beat 0, EOB only on beat 3. done_o pulses with beat 3. Bits 1021:992 = 0.
- K=1 -> single beat with bits 1023 and 1022 both 1, one done_o.
- K=8, rtr_i low for 5 cycles mid-block -> skid fills to 2 and a_rtr_o/b_rtr_o drop. No beat is lost or duplicated, data_o is stable while stalled. Macro on: stall_cnt_o=5.
- A valid every cycle, B valid only on odd cycles, K=3 -> fire only when both are valid. A is never consumed alone; output words are paired in order.
- cfg_k_i=0 -> cfg_err_o=1, FSM stays IDLE, no beats. A following K=2 request completes normally.
- rst_n low for 1 cycle during beat 2 of K=6 -> rts_o=0 immediately and cfg_ready_o=1. A new K=2 block then starts with SOB=1.
